// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32I decoder feeding a DEPTH-entry issue FIFO.
// Optional DECODE_QUEUE_ILLEGAL_TRAP_EN enqueues unknown opcodes as TExc entries.
module decode_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int OP_W   = 6,
   parameter int TAG_W  = 4,
   parameter int NAME_W = 5,
   parameter int TYPE_W = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   input  logic                       iq_valid_i,
   output logic                       iq_ready_o,
   input  logic [31:0]                inst_i,
   input  logic [ADDR_W-1:0]          pc_i,
   input  logic                       bp_i,
   input  logic                       rob_valid_i,
   input  logic [TAG_W-1:0]           rob_tag_i,
   input  logic                       rs_valid_i,
   input  logic                       ls_rs_valid_i,
   input  logic                       br_rs_valid_i,
   output logic                       disp_en_o,
   output logic [OP_W-1:0]            op_o,
   output logic [DATA_W-1:0]          imm_o,
   output logic [ADDR_W-1:0]          pc_o,
   output logic                       bp_o,
   output logic [1:0]                 cls_o,
   output logic                       reg1_re_o,
   output logic                       reg2_re_o,
   output logic [NAME_W-1:0]          reg1_o,
   output logic [NAME_W-1:0]          reg2_o,
   output logic                       rd_we_o,
   output logic [NAME_W-1:0]          rd_addr_o,
   output logic [TAG_W-1:0]           des_o,
   output logic                       rob_we_o,
   output logic [NAME_W-1:0]          rob_addr_o,
   output logic [TYPE_W-1:0]          rob_type_o,
   output logic                       rob_bp_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] CLS_ALU = 2'd0, CLS_LS = 2'd1, CLS_BR = 2'd2;
   localparam logic [TYPE_W-1:0] T_REG  = TYPE_W'(1), T_BOTH = TYPE_W'(2), T_PC  = TYPE_W'(3),
                                 T_LOAD = TYPE_W'(4), T_MEM  = TYPE_W'(5), T_EXC = TYPE_W'(6);

   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign f3    = inst_i[14:12];
   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'h000};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   logic              d_known, d_we, d_isbr;
   logic [OP_W-1:0]   d_op;
   logic [31:0]       d_imm;
   logic [1:0]        d_cls;
   logic [NAME_W-1:0] d_r1, d_r2, d_rd;
   logic [TYPE_W-1:0] d_type;

   // Op code = {group, alt, funct3}; alt marks SUB/SRA/SRAI.
   always_comb begin
      d_known = 1'b1;
      d_we    = 1'b0;
      d_isbr  = 1'b0;
      d_op    = '0;
      d_imm   = '0;
      d_cls   = CLS_ALU;
      d_r1    = '0;
      d_r2    = '0;
      d_type  = T_REG;
      case (inst_i[6:0])
         7'b0110111: begin d_op = OP_W'(1); d_imm = imm_u; d_we = 1'b1; end
         7'b0010111: begin d_op = OP_W'(2); d_imm = imm_u; d_we = 1'b1; end
         7'b1101111: begin
            d_op = OP_W'(3); d_imm = imm_j; d_we = 1'b1; d_cls = CLS_BR; d_isbr = 1'b1; d_type = T_BOTH;
         end
         7'b1100111: begin
            d_op = OP_W'(4); d_imm = imm_i; d_r1 = NAME_W'(inst_i[19:15]); d_we = 1'b1;
            d_cls = CLS_BR; d_isbr = 1'b1; d_type = T_BOTH;
         end
         7'b1100011: begin
            d_op = OP_W'({3'b001, f3}); d_imm = imm_b; d_r1 = NAME_W'(inst_i[19:15]);
            d_r2 = NAME_W'(inst_i[24:20]); d_cls = CLS_BR; d_isbr = 1'b1; d_type = T_PC;
         end
         7'b0000011: begin
            d_op = OP_W'({3'b010, f3}); d_imm = imm_i; d_r1 = NAME_W'(inst_i[19:15]);
            d_we = 1'b1; d_cls = CLS_LS; d_type = T_LOAD;
         end
         7'b0100011: begin
            d_op = OP_W'({3'b011, f3}); d_imm = imm_s; d_r1 = NAME_W'(inst_i[19:15]);
            d_r2 = NAME_W'(inst_i[24:20]); d_cls = CLS_LS; d_type = T_MEM;
         end
         7'b0010011: begin
            d_op  = OP_W'({2'b10, (f3 == 3'd5) && inst_i[30], f3});
            d_imm = (f3 == 3'd1 || f3 == 3'd5) ? {26'h0, inst_i[25:20]} : imm_i;
            d_r1  = NAME_W'(inst_i[19:15]); d_we = 1'b1;
         end
         7'b0110011: begin
            d_op = OP_W'({2'b11, (f3 == 3'd0 || f3 == 3'd5) && inst_i[30], f3});
            d_r1 = NAME_W'(inst_i[19:15]); d_r2 = NAME_W'(inst_i[24:20]); d_we = 1'b1;
         end
         default: begin d_known = 1'b0; d_type = T_EXC; end
      endcase
   end

   assign d_rd = d_we ? NAME_W'(inst_i[11:7]) : '0;

   logic enq_ok;
`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
   assign enq_ok = 1'b1;
`else
   assign enq_ok = d_known;
`endif

   logic [OP_W-1:0]   op_q   [DEPTH];
   logic [DATA_W-1:0] imm_q  [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic              bp_q   [DEPTH];
   logic [1:0]        cls_q  [DEPTH];
   logic [NAME_W-1:0] r1_q   [DEPTH];
   logic [NAME_W-1:0] r2_q   [DEPTH];
   logic [NAME_W-1:0] rd_q   [DEPTH];
   logic              we_q   [DEPTH];
   logic [TYPE_W-1:0] type_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;

   logic accept, wr, rs_ok, issue;
   assign iq_ready_o = (count_q < CNT_W'(DEPTH)) && !clear_i;
   assign accept     = iq_valid_i && iq_ready_o;
   assign wr         = accept && enq_ok;

   always_comb begin
      case (cls_q[head_q])
         CLS_ALU: rs_ok = rs_valid_i;
         CLS_LS:  rs_ok = ls_rs_valid_i;
         CLS_BR:  rs_ok = br_rs_valid_i;
         default: rs_ok = 1'b0;
      endcase
   end
   assign issue = valid_q[head_q] && rob_valid_i && rs_ok && !clear_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else if (clear_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (wr) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         if (issue) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         count_q <= count_q + CNT_W'(wr) - CNT_W'(issue);
      end
   end

   // Payload needs no reset: valid_q and the issue gate hide stale entries.
   always_ff @(posedge clk) begin
      if (wr) begin
         op_q[tail_q]   <= d_op;
         imm_q[tail_q]  <= DATA_W'($signed(d_imm));
         pc_q[tail_q]   <= pc_i;
         bp_q[tail_q]   <= bp_i && d_isbr;
         cls_q[tail_q]  <= d_cls;
         r1_q[tail_q]   <= d_r1;
         r2_q[tail_q]   <= d_r2;
         rd_q[tail_q]   <= d_rd;
         we_q[tail_q]   <= d_we;
         type_q[tail_q] <= d_type;
      end
   end

   assign disp_en_o  = issue;
   assign op_o       = issue ? op_q[head_q]   : '0;
   assign imm_o      = issue ? imm_q[head_q]  : '0;
   assign pc_o       = issue ? pc_q[head_q]   : '0;
   assign bp_o       = issue && bp_q[head_q];
   assign cls_o      = issue ? cls_q[head_q]  : '0;
   assign reg1_re_o  = issue;
   assign reg2_re_o  = issue;
   assign reg1_o     = issue ? r1_q[head_q]   : '0;
   assign reg2_o     = issue ? r2_q[head_q]   : '0;
   assign rd_we_o    = issue && we_q[head_q];
   assign rd_addr_o  = issue ? rd_q[head_q]   : '0;
   assign des_o      = issue ? rob_tag_i      : '0;
   assign rob_we_o   = issue;
   assign rob_addr_o = issue ? rd_q[head_q]   : '0;
   assign rob_type_o = issue ? type_q[head_q] : '0;
   assign rob_bp_o   = issue && bp_q[head_q];
   assign count_o    = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized bench for decode_queue against a queue-based reference.
module tb_decode_queue;
   localparam int DEPTH = 4;
   localparam logic [2:0] T_REG = 3'd1, T_BOTH = 3'd2, T_PC = 3'd3, T_LOAD = 3'd4, T_MEM = 3'd5, T_EXC = 3'd6;

   logic        clk = 1'b0, rst_n = 1'b0, clear_i = 1'b0, iq_valid_i = 1'b0, bp_i = 1'b0;
   logic [31:0] inst_i = '0, pc_i = '0;
   logic        rob_valid_i = 1'b0, rs_valid_i = 1'b0, ls_rs_valid_i = 1'b0, br_rs_valid_i = 1'b0;
   logic [3:0]  rob_tag_i = '0;
   logic        iq_ready_o, disp_en_o, bp_o, reg1_re_o, reg2_re_o, rd_we_o, rob_we_o, rob_bp_o;
   logic [5:0]  op_o;
   logic [31:0] imm_o, pc_o;
   logic [1:0]  cls_o;
   logic [4:0]  reg1_o, reg2_o, rd_addr_o, rob_addr_o;
   logic [3:0]  des_o;
   logic [2:0]  rob_type_o;
   logic [2:0]  count_o;

   decode_queue dut (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .iq_valid_i(iq_valid_i), .iq_ready_o(iq_ready_o),
      .inst_i(inst_i), .pc_i(pc_i), .bp_i(bp_i), .rob_valid_i(rob_valid_i), .rob_tag_i(rob_tag_i),
      .rs_valid_i(rs_valid_i), .ls_rs_valid_i(ls_rs_valid_i), .br_rs_valid_i(br_rs_valid_i),
      .disp_en_o(disp_en_o), .op_o(op_o), .imm_o(imm_o), .pc_o(pc_o), .bp_o(bp_o), .cls_o(cls_o),
      .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
      .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .des_o(des_o), .rob_we_o(rob_we_o),
      .rob_addr_o(rob_addr_o), .rob_type_o(rob_type_o), .rob_bp_o(rob_bp_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        bp;
      logic [1:0]  cls;
      logic [4:0]  r1, r2, rd;
      logic        we;
      logic [2:0]  rt;
   } ent_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        bp;
   } src_t;

   ent_t mq[$];
   src_t src[$];
   int   n_vec = 0, n_bad = 0, gap_pct = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input logic bp,
                                       output bit keep);
      ent_t e;
      logic [2:0]  f = w[14:12];
      logic [31:0] ii = {{20{w[31]}}, w[31:20]};
      e = '0;
      keep = 1;
      e.pc = pc;
      e.rt = T_REG;
      case (w[6:0])
         7'h37: begin e.op = 6'd1; e.imm = {w[31:12], 12'h0}; e.we = 1; end
         7'h17: begin e.op = 6'd2; e.imm = {w[31:12], 12'h0}; e.we = 1; end
         7'h6F: begin
            e.op = 6'd3; e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            e.we = 1; e.cls = 2; e.rt = T_BOTH;
         end
         7'h67: begin e.op = 6'd4; e.imm = ii; e.r1 = w[19:15]; e.we = 1; e.cls = 2; e.rt = T_BOTH; end
         7'h63: begin
            e.op = 6'd8 + 6'(f); e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            e.r1 = w[19:15]; e.r2 = w[24:20]; e.cls = 2; e.rt = T_PC;
         end
         7'h03: begin e.op = 6'd16 + 6'(f); e.imm = ii; e.r1 = w[19:15]; e.we = 1; e.cls = 1; e.rt = T_LOAD; end
         7'h23: begin
            e.op = 6'd24 + 6'(f); e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            e.r1 = w[19:15]; e.r2 = w[24:20]; e.cls = 1; e.rt = T_MEM;
         end
         7'h13: begin
            e.op  = 6'd32 + 6'(f) + ((f == 5 && w[30]) ? 6'd8 : 6'd0);
            e.imm = (f == 1 || f == 5) ? {26'h0, w[25:20]} : ii;
            e.r1  = w[19:15]; e.we = 1;
         end
         7'h33: begin
            e.op = 6'd48 + 6'(f) + (((f == 0 || f == 5) && w[30]) ? 6'd8 : 6'd0);
            e.r1 = w[19:15]; e.r2 = w[24:20]; e.we = 1;
         end
         default: begin
`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
            e.rt = T_EXC;
`else
            keep = 0;
`endif
         end
      endcase
      e.bp = (e.cls == 2) ? bp : 1'b0;
      e.rd = e.we ? w[11:7] : 5'd0;
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w = $urandom;
      logic [2:0]  f;
      logic [6:0]  bad [3] = '{7'h7F, 7'h0F, 7'h73};
      case ($urandom_range(0, 10))
         0: w[6:0] = 7'h37;
         1: w[6:0] = 7'h17;
         2: w[6:0] = 7'h6F;
         3: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
         4: begin w[6:0] = 7'h63; f = 3'($urandom_range(0, 5)); w[14:12] = (f < 2) ? f : f + 3'd2; end
         5: begin w[6:0] = 7'h03; f = 3'($urandom_range(0, 4)); w[14:12] = (f < 3) ? f : f + 3'd1; end
         6: begin w[6:0] = 7'h23; w[14:12] = 3'($urandom_range(0, 2)); end
         7, 8: begin
            w[6:0] = 7'h13;
            if (w[14:12] == 1) w[31:25] = 7'h00;
            if (w[14:12] == 5) w[31:25] = w[30] ? 7'h20 : 7'h00;
         end
         9: begin
            w[6:0] = 7'h33;
            w[31:25] = ((w[14:12] == 0 || w[14:12] == 5) && w[30]) ? 7'h20 : 7'h00;
         end
         default: w[6:0] = bad[$urandom_range(0, 2)];
      endcase
      return w;
   endfunction

   function automatic bit st_ok(input logic [1:0] c);
      return (c == 0) ? rs_valid_i : (c == 1) ? ls_rs_valid_i : br_rs_valid_i;
   endfunction

   task automatic push_inst(input logic [31:0] w, input logic [31:0] pc, input logic bp);
      src.push_back('{inst: w, pc: pc, bp: bp});
   endtask

   task automatic drive_src();
      iq_valid_i = (src.size() > 0) && ($urandom_range(1, 100) > gap_pct);
      if (src.size() > 0) begin
         inst_i = src[0].inst; pc_i = src[0].pc; bp_i = src[0].bp;
      end
   endtask

   // Called at the negedge: compares against the model, then advances it by one clock.
   task automatic model_step();
      bit   exp_ready, acc, iss, keep;
      ent_t e;
      exp_ready = (mq.size() < DEPTH) && !clear_i;
      acc = iq_valid_i && exp_ready;
      iss = !clear_i && (mq.size() > 0) && rob_valid_i && st_ok(mq[0].cls);
      check("iq_ready", 64'(iq_ready_o), 64'(exp_ready));
      check("count", 64'(count_o), 64'(mq.size()));
      check("disp_en", 64'(disp_en_o), 64'(iss));
      if (iss) begin
         e = mq[0];
         check("op", 64'(op_o), 64'(e.op));
         check("imm", 64'(imm_o), 64'(e.imm));
         check("pc", 64'(pc_o), 64'(e.pc));
         check("bp", 64'({bp_o, rob_bp_o}), 64'({e.bp, e.bp}));
         check("cls", 64'(cls_o), 64'(e.cls));
         check("re", 64'({reg1_re_o, reg2_re_o, rob_we_o}), 64'(3'b111));
         check("regs", 64'({reg1_o, reg2_o}), 64'({e.r1, e.r2}));
         check("rd", 64'({rd_we_o, rd_addr_o, rob_addr_o}), 64'({e.we, e.rd, e.rd}));
         check("des", 64'(des_o), 64'(rob_tag_i));
         check("rob_type", 64'(rob_type_o), 64'(e.rt));
      end else begin
         check("idle_zero", 64'(|{op_o, imm_o, pc_o, bp_o, cls_o, reg1_re_o, reg2_re_o, reg1_o, reg2_o,
                                  rd_we_o, rd_addr_o, des_o, rob_we_o, rob_addr_o, rob_type_o, rob_bp_o}), 64'(0));
      end
      if (clear_i) mq.delete();
      else begin
         if (iss) void'(mq.pop_front());
         if (acc) begin
            e = ref_decode(inst_i, pc_i, bp_i, keep);
            if (keep) mq.push_back(e);
         end
      end
      if (acc) void'(src.pop_front());
   endtask

   task automatic cyc();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      drive_src();
   endtask

   task automatic stations(input logic rob, input logic alu, input logic ls, input logic br);
      rob_valid_i = rob; rs_valid_i = alu; ls_rs_valid_i = ls; br_rs_valid_i = br;
   endtask

   initial begin
      // Reset and idle
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(iq_ready_o), 64'(1));
      check("rst_count", 64'(count_o), 64'(0));
      check("rst_outs", 64'(|{disp_en_o, op_o, imm_o, pc_o, bp_o, cls_o, reg1_re_o, reg2_re_o, reg1_o,
                              reg2_o, rd_we_o, rd_addr_o, des_o, rob_we_o, rob_addr_o, rob_type_o, rob_bp_o}), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (3) cyc();

      // Single ADDI x5,x1,-3
      stations(1, 1, 1, 1);
      rob_tag_i = 4'd3;
      push_inst(32'hFFD08293, 32'h100, 1'b0);
      drive_src();
      cyc();
      @(negedge clk);
      check("addi_disp", 64'(disp_en_o), 64'(1));
      check("addi_op", 64'(op_o), 64'(6'h20));
      check("addi_imm", 64'(imm_o), 64'(32'hFFFFFFFD));
      check("addi_fields", 64'({reg1_o, rd_addr_o, rd_we_o, des_o, rob_type_o}), 64'({5'd1, 5'd5, 1'b1, 4'd3, T_REG}));
      check("addi_pc", 64'(pc_o), 64'(32'h100));
      model_step();
      @(posedge clk); #1; drive_src();

      // Fill to full, then drain in order
      stations(0, 1, 1, 1);
      for (int i = 0; i < 5; i++) push_inst(32'h00000013 | (32'(i + 1) << 7) | (32'(i) << 20), 32'h200 + 32'(4 * i), 1'b0);
      drive_src();
      repeat (6) cyc();
      check("full_count", 64'(count_o), 64'(DEPTH));
      check("full_ready", 64'(iq_ready_o), 64'(0));
      rob_valid_i = 1'b1;
      repeat (8) cyc();

      // Class stall: LW blocks a younger ADD
      stations(1, 1, 0, 1);
      push_inst(32'h00412383, 32'h300, 1'b0);
      push_inst(32'h002081B3, 32'h304, 1'b0);
      drive_src();
      repeat (4) cyc();
      check("stall_count", 64'(count_o), 64'(2));
      ls_rs_valid_i = 1'b1;
      @(negedge clk);
      check("lw_first", 64'({disp_en_o, op_o, rob_type_o}), 64'({1'b1, 6'h12, T_LOAD}));
      model_step();
      @(posedge clk); #1; drive_src();
      repeat (3) cyc();

      // BEQ x1,x2,-8 predicted taken
      push_inst(32'hFE208CE3, 32'h400, 1'b1);
      drive_src();
      cyc();
      @(negedge clk);
      check("beq", 64'({disp_en_o, bp_o, rob_bp_o, rd_we_o, rob_type_o, op_o}),
            64'({1'b1, 1'b1, 1'b1, 1'b0, T_PC, 6'h08}));
      check("beq_imm", 64'(imm_o), 64'(32'hFFFFFFF8));
      model_step();
      @(posedge clk); #1; drive_src();

      // Flush with 3 queued and a valid instruction waiting
      stations(0, 1, 1, 1);
      for (int i = 0; i < 4; i++) push_inst(rand_inst(), 32'h500 + 32'(4 * i), 1'b1);
      src[0].inst = 32'h00100093; src[1].inst = 32'h00200113; src[2].inst = 32'h00300193;
      src[3].inst = 32'h00400213;
      drive_src();
      repeat (3) cyc();
      clear_i = 1'b1;
      rob_valid_i = 1'b1;
      @(negedge clk);
      check("flush_noacc", 64'({iq_ready_o, disp_en_o}), 64'(0));
      model_step();
      @(posedge clk); #1; clear_i = 1'b0; rob_valid_i = 1'b0; drive_src();
      @(negedge clk);
      check("flush_count", 64'(count_o), 64'(0));
      model_step();
      @(posedge clk); #1; drive_src();
      rob_valid_i = 1'b1;
      repeat (3) cyc();

      // Wrap: 6 through the FIFO
      for (int i = 0; i < 6; i++) push_inst(rand_inst(), 32'h600 + 32'(4 * i), 1'($urandom));
      drive_src();
      repeat (12) cyc();

      // Randomized traffic
      gap_pct = 20;
      for (int n = 0; n < 600; n++) begin
         if (src.size() < 3) push_inst(rand_inst(), $urandom, 1'($urandom));
         stations($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
         rob_tag_i = 4'($urandom);
         clear_i = ($urandom_range(0, 99) < 3);
         drive_src();
         @(negedge clk);
         model_step();
         @(posedge clk); #1;
      end
      clear_i = 1'b0;

      // Asynchronous reset mid-operation
      stations(0, 1, 1, 1);
      gap_pct = 0;
      for (int i = 0; i < 2; i++) push_inst(32'h00000033, 32'h700, 1'b0);
      drive_src();
      repeat (4) cyc();
      iq_valid_i = 1'b0;
      src.delete();
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 64'(count_o), 64'(0));
      check("arst_ready", 64'({iq_ready_o, disp_en_o}), 64'(2'b10));
      mq.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      rob_valid_i = 1'b1;
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
